elevator_ctrl: RTL
==================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, 4, number of floors served (2..8); floors are numbered 0..NUM_FLOORS-1.
REQ-002 Parameter TRAVEL_CYCLES, 50, clock cycles to move the car one floor (>=2).
REQ-003 Parameter DOOR_CYCLES, 100, clock cycles the door stays open per stop (>=2).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_i  input  NUM_FLOORS  floor call buttons; one bit per floor; a 1-cycle pulse is sufficient.
REQ-008 floor_o  output  clog2(NUM_FLOORS)  current car floor.
REQ-009 motor_up_o  output  1  motor drive upward.
REQ-010 motor_dn_o  output  1  motor drive downward.
REQ-011 door_open_o  output  1  door open command.
REQ-012 pending_o  output  NUM_FLOORS  latched, not-yet-served calls.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN; motor_up_o=1 only in MOVE_UP, motor_dn_o=1 only in MOVE_DN, door_open_o=1 only in DOOR_OPEN; motor_up_o and motor_dn_o are never high together.
REQ-015 Each req_i bit SHALL be OR-ed into pending on the next clock edge; a pending bit is cleared only when the car enters DOOR_OPEN at that floor.
REQ-016 IDLE: pending at floor_o -> DOOR_OPEN next cycle; else pending above -> MOVE_UP; else pending below -> MOVE_DN; else stay IDLE.
REQ-017 MOVE_*: a travel counter runs 0..TRAVEL_CYCLES-1; on the cycle it reaches TRAVEL_CYCLES-1, floor_o SHALL increment (UP) or decrement (DN) and the counter restarts.
REQ-018 On arrival, pending at the new floor -> DOOR_OPEN; otherwise the car continues in the same direction.
REQ-019 DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles; a call for floor_o arriving during DOOR_OPEN SHALL restart the door counter and SHALL NOT set its pending bit.
REQ-020 On DOOR_OPEN expiry, scheduling SHALL follow a SCAN policy: keep the last direction while pending calls exist beyond the car in that direction; else reverse if calls exist the other way; else IDLE.
REQ-021 The car SHALL never move below floor 0 or above NUM_FLOORS-1; MOVE_UP at the top floor or MOVE_DN at floor 0 is unreachable and SHALL be covered by an assertion.
REQ-022 Calls for floors already passed SHALL remain pending until the reverse sweep serves them.

Reset
REQ-023 While reset=1: state=IDLE, floor_o=0, pending_o=0, counters=0, all motor/door outputs 0, last direction=up; reset mid-move SHALL abandon the move immediately.

Configuration
REQ-024 Macro ELEVATOR_OVERLOAD_EN: when defined, it adds input overload_i (1 bit); while overload_i=1 in DOOR_OPEN, the door counter SHALL hold and the door stays open. When undefined, the port does not exist and door timing is unconditional.

Structure
REQ-025 Package elevator_pkg SHALL hold the state enum, the direction type and the floor-width function/constant.
REQ-026 Sub-module elevator_timer (load, enable, terminal-count flag) SHALL be instantiated twice: once for travel, once for door.

Verification (bench parameters: NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Reset, then pulse req_i=4'b1000 -> motor_up_o rises 2 cycles later; floor_o reaches 3 after 12 cycles of motion; door_open_o high 3 cycles; pending_o=0; IDLE.
REQ-028 Car idle at floor 0, pulse req_i=4'b0001 -> door_open_o high for exactly 3 cycles starting 2 cycles after the pulse; no motor activity.
REQ-029 Car moving up from 0 toward 3, pulse req_i=4'b0100 before the car reaches 2 -> stop at 2, then 3, and pending clears in order.
REQ-030 Car at 2 heading up with calls at 3 and 0 pending -> service order is 3 then 0 (SCAN); floor 1 is passed without stopping.
REQ-031 Assert reset while in MOVE_UP mid-count -> next cycle floor_o=0, all outputs 0, pending_o=0.
REQ-032 With ELEVATOR_OVERLOAD_EN defined, hold overload_i=1 for 10 cycles in DOOR_OPEN -> door_open_o stays high for 10+3 cycles total.

Source files
------------

// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : shared state/direction types and floor-width helper
// Revision     : 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DN   = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

   localparam int MIN_FLOOR_W = 1;

   function automatic int floor_width(input int num_floors);
      return ($clog2(num_floors) < MIN_FLOOR_W) ? MIN_FLOOR_W : $clog2(num_floors);
   endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_timer.sv
// ============================================================================
// elevator_timer : wrapping 0..CYCLES-1 counter with load and terminal flag
// Revision       : 1.0
// ============================================================================
`default_nettype none

module elevator_timer #(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic done
);

   localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   // Terminal count only qualifies while counting, so a held timer never expires
   assign done = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/elevator_ctrl.sv
// ============================================================================
// elevator_ctrl : single-car SCAN elevator controller
// Option        : ELEVATOR_OVERLOAD_EN adds overload_i (holds door open)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter  int NUM_FLOORS    = 4,
   parameter  int TRAVEL_CYCLES = 50,
   parameter  int DOOR_CYCLES   = 100,
   localparam int FW            = floor_width(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] req_i,
`ifdef ELEVATOR_OVERLOAD_EN
   input  logic                  overload_i,
`endif
   output logic [FW-1:0]         floor_o,
   output logic                  motor_up_o,
   output logic                  motor_dn_o,
   output logic                  door_open_o,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic                  busy_o
);

   state_t                state, state_nxt;
   dir_t                  dir, dir_nxt;
   logic [FW-1:0]         cur_floor, floor_nxt;
   logic [NUM_FLOORS-1:0] pending, pending_nxt;
   logic                  above, below;
   logic                  moving, door_restart, hold;
   logic                  travel_done, door_done;

`ifdef ELEVATOR_OVERLOAD_EN
   assign hold = overload_i;
`else
   assign hold = 1'b0;
`endif

   assign moving = (state == MOVE_UP) || (state == MOVE_DN);

   elevator_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (!moving),
      .enable (moving),
      .done   (travel_done)
   );

   elevator_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
      .clk    (clk),
      .reset  (reset),
      .load   ((state != DOOR_OPEN) || door_restart),
      .enable ((state == DOOR_OPEN) && !hold),
      .done   (door_done)
   );

   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(cur_floor)) above = above | pending[i];
         if (i < int'(cur_floor)) below = below | pending[i];
      end
   end

   always_comb begin
      state_nxt    = state;
      dir_nxt      = dir;
      floor_nxt    = cur_floor;
      door_restart = 1'b0;
      case (state)
         IDLE: begin
            if (pending[cur_floor]) begin
               state_nxt = DOOR_OPEN;
            end else if (above) begin
               state_nxt = MOVE_UP;
               dir_nxt   = DIR_UP;
            end else if (below) begin
               state_nxt = MOVE_DN;
               dir_nxt   = DIR_DN;
            end
         end
         MOVE_UP: begin
            if (travel_done) begin
               floor_nxt = cur_floor + FW'(1);
               if (pending[floor_nxt]) state_nxt = DOOR_OPEN;
            end
         end
         MOVE_DN: begin
            if (travel_done) begin
               floor_nxt = cur_floor - FW'(1);
               if (pending[floor_nxt]) state_nxt = DOOR_OPEN;
            end
         end
         DOOR_OPEN: begin
            if (req_i[cur_floor]) begin
               door_restart = 1'b1;
            end else if (door_done) begin
               // SCAN: prefer the current sweep, reverse only when it is exhausted
               if ((dir == DIR_UP && above) || (dir == DIR_DN && !below && above)) begin
                  state_nxt = MOVE_UP;
                  dir_nxt   = DIR_UP;
               end else if (below) begin
                  state_nxt = MOVE_DN;
                  dir_nxt   = DIR_DN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pending_nxt = pending | req_i;
      if (state == DOOR_OPEN)     pending_nxt[cur_floor] = 1'b0;
      if (state_nxt == DOOR_OPEN) pending_nxt[floor_nxt] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dir       <= DIR_UP;
         cur_floor <= '0;
         pending   <= '0;
      end else begin
         state     <= state_nxt;
         dir       <= dir_nxt;
         cur_floor <= floor_nxt;
         pending   <= pending_nxt;
      end
   end

   assign floor_o     = cur_floor;
   assign motor_up_o  = (state == MOVE_UP);
   assign motor_dn_o  = (state == MOVE_DN);
   assign door_open_o = (state == DOOR_OPEN);
   assign pending_o   = pending;
   assign busy_o      = (state != IDLE);

   a_no_up_at_top : assert property (@(posedge clk) disable iff (reset)
      !(state == MOVE_UP && cur_floor == FW'(NUM_FLOORS - 1)));
   a_no_dn_at_bottom : assert property (@(posedge clk) disable iff (reset)
      !(state == MOVE_DN && cur_floor == '0));
   a_motor_exclusive : assert property (@(posedge clk) !(motor_up_o && motor_dn_o));

endmodule

`default_nettype wire
